// File: rtl/un_striping_pkg.sv
// Shared definitions for the striping / un_striping lane pair: widths, lane count,
// selector encoding and the FIFO push-acceptance rule.
package un_striping_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 4;
   localparam int LANE_COUNT = 2;

   typedef enum logic {
      EXP0 = 1'b0,
      EXP1 = 1'b1
   } sel_t;

   // A full FIFO still takes a word when its head leaves on the same edge.
   function automatic logic lane_accept(input logic full, input logic popping);
      return !full || popping;
   endfunction

endpackage

// File: rtl/un_striping_lane_fifo.sv
// Per-lane skew FIFO: registered storage, combinational head, power-of-2 depth
// with free-running wrapping pointers.
module lane_fifo
   import un_striping_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic [AW:0]       count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   assign do_push = push && lane_accept(full, do_pop);

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk_2f) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/un_striping.sv
// Merges lane_0 (even words) and lane_1 (odd words) back into one ordered stream,
// absorbing inter-lane skew in per-lane FIFOs and flagging dropped words.
module un_striping
   import un_striping_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic [DATA_W-1:0] lane_0,
   input  logic              valid_0,
   input  logic [DATA_W-1:0] lane_1,
   input  logic              valid_1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              overflow_err
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0]     lane_word  [LANE_COUNT];
   logic [DATA_W-1:0]     lane_head  [LANE_COUNT];
   logic [AW:0]           lane_count [LANE_COUNT];
   logic [LANE_COUNT-1:0] lane_valid;
   logic [LANE_COUNT-1:0] lane_empty;
   logic [LANE_COUNT-1:0] lane_full;
   logic [LANE_COUNT-1:0] lane_pop;
   logic [LANE_COUNT-1:0] lane_drop;

   sel_t              sel_reg, sel_next;
   logic [DATA_W-1:0] data_out_reg, data_out_next;
   logic              valid_out_reg, valid_out_next;
   logic              overflow_err_reg, overflow_err_next;

   assign lane_word[0] = lane_0;
   assign lane_word[1] = lane_1;
   assign lane_valid   = {valid_1, valid_0};

   // Only the lane the selector expects may pop; the other lane waits even if it has data.
   assign lane_pop[0] = (sel_reg == EXP0) && !lane_empty[0];
   assign lane_pop[1] = (sel_reg == EXP1) && !lane_empty[1];

   genvar gi;
   generate
      for (gi = 0; gi < LANE_COUNT; gi++) begin : g_lane
         lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
         ) u_fifo (
            .clk_2f (clk_2f),
            .reset  (reset),
            .push   (lane_valid[gi]),
            .pop    (lane_pop[gi]),
            .din    (lane_word[gi]),
            .dout   (lane_head[gi]),
            .empty  (lane_empty[gi]),
            .full   (lane_full[gi]),
            .count  (lane_count[gi])
         );
         assign lane_drop[gi] = lane_valid[gi] && !lane_accept(lane_full[gi], lane_pop[gi]);
      end
   endgenerate

   // Occupancy is exported by the FIFO for observation; the merge only needs empty/full.
   logic lane_count_unused;
   assign lane_count_unused = ^{lane_count[0], lane_count[1]};

   always_comb begin
      sel_next          = sel_reg;
      data_out_next     = data_out_reg;
      valid_out_next    = 1'b0;
      overflow_err_next = overflow_err_reg | (|lane_drop);
      case (sel_reg)
         EXP0: begin
            if (lane_pop[0]) begin
               data_out_next  = lane_head[0];
               valid_out_next = 1'b1;
               sel_next       = EXP1;
            end
         end
         EXP1: begin
            if (lane_pop[1]) begin
               data_out_next  = lane_head[1];
               valid_out_next = 1'b1;
               sel_next       = EXP0;
            end
         end
         default: sel_next = EXP0;
      endcase
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         sel_reg          <= EXP0;
         data_out_reg     <= '0;
         valid_out_reg    <= 1'b0;
         overflow_err_reg <= 1'b0;
      end else begin
         sel_reg          <= sel_next;
         data_out_reg     <= data_out_next;
         valid_out_reg    <= valid_out_next;
         overflow_err_reg <= overflow_err_next;
      end
   end

   assign data_out     = data_out_reg;
   assign valid_out    = valid_out_reg;
   assign overflow_err = overflow_err_reg;

endmodule

// File: tb/tb_un_striping.sv
// Scoreboard bench for un_striping: a queue-level lane model predicts each merged word
// and the sticky drop flag; a negedge monitor checks every cycle against it.
module tb_un_striping;
   import un_striping_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk_2f = 1'b0;
   logic          reset  = 1'b1;
   logic [DW-1:0] lane_0 = '0;
   logic [DW-1:0] lane_1 = '0;
   logic          valid_0 = 1'b0;
   logic          valid_1 = 1'b0;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          overflow_err;

   un_striping #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk_2f       (clk_2f),
      .reset        (reset),
      .lane_0       (lane_0),
      .valid_0      (valid_0),
      .lane_1       (lane_1),
      .valid_1      (valid_1),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .overflow_err (overflow_err)
   );

   always #5 clk_2f = ~clk_2f;

   // Reference model: each lane is a bounded queue of words; the stream alternates
   // lanes strictly, taking a word only when the expected lane has one.
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [DW-1:0] exp_q [$];
   bit            want_lane1 = 0;
   bit            m_valid = 0;
   logic [DW-1:0] m_last = '0;
   bit            m_ovf = 0;
   bit            started = 0;

   int compared   = 0;
   int mismatched = 0;

   task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
      end
   endtask

   always @(posedge clk_2f) begin
      if (reset) begin
         q0.delete();
         q1.delete();
         exp_q.delete();
         want_lane1 = 0;
         m_valid    = 0;
         m_last     = '0;
         m_ovf      = 0;
         started    = 1;
      end else begin
         m_valid = 0;
         if (!want_lane1 && q0.size() > 0) begin
            m_last = q0.pop_front();
            exp_q.push_back(m_last);
            m_valid    = 1;
            want_lane1 = 1;
         end else if (want_lane1 && q1.size() > 0) begin
            m_last = q1.pop_front();
            exp_q.push_back(m_last);
            m_valid    = 1;
            want_lane1 = 0;
         end
         // A word leaving this edge frees its slot for an arriving word.
         if (valid_0) begin
            if (q0.size() < DEPTH) q0.push_back(lane_0);
            else m_ovf = 1;
         end
         if (valid_1) begin
            if (q1.size() < DEPTH) q1.push_back(lane_1);
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk_2f) begin
      if (started) begin
         cmp("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
         cmp("overflow_err", {31'b0, overflow_err}, {31'b0, m_ovf});
         if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
               cmp("unexpected_word", data_out, 32'hxxxx_xxxx);
            end else begin
               logic [DW-1:0] exp_word;
               exp_word = exp_q.pop_front();
               $display("word out %h expected %h at %0t", data_out, exp_word, $time);
               cmp("data_out", data_out, exp_word);
            end
         end else begin
            cmp("data_hold", data_out, m_last);
         end
      end
   end

   task automatic step(input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1);
      @(negedge clk_2f);
      valid_0 = v0;
      lane_0  = d0;
      valid_1 = v1;
      lane_1  = d1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
   endtask

   task automatic pulse_reset();
      @(negedge clk_2f);
      valid_0 = 1'b0;
      valid_1 = 1'b0;
      reset   = 1'b1;
      @(negedge clk_2f);
      reset   = 1'b0;
   endtask

   initial begin
      int p0;
      int p1;
      repeat (2) @(negedge clk_2f);
      reset = 1'b0;

      // In-order pair of beats
      step(1, 32'hFFFF_FFFF, 1, 32'hEEEE_EEEE);
      step(1, 32'hDDDD_DDDD, 1, 32'hCCCC_CCCC);
      idle(6);

      // Lane 1 leads lane 0 by three cycles
      step(0, '0, 1, 32'hEEEE_EEEE);
      idle(2);
      step(1, 32'hFFFF_FFFF, 0, '0);
      idle(5);

      // Gap between pairs
      step(1, 32'h0000_0001, 1, 32'h0000_0002);
      idle(2);
      step(1, 32'h0000_0003, 1, 32'h0000_0004);
      idle(6);

      // Lane 1 overflow, then lane 0 releases the queue
      for (int i = 0; i < 5; i++) step(0, '0, 1, 32'hA0 + i);
      idle(2);
      step(1, 32'hB0, 0, '0);
      idle(8);

      // Fill fifo_0 while waiting on lane 1, then push into it as it pops
      pulse_reset();
      step(1, 32'hC0, 0, '0);
      for (int i = 1; i <= 4; i++) step(1, 32'hC0 + i, 0, '0);
      step(0, '0, 1, 32'hD0);
      idle(1);
      step(1, 32'hC5, 0, '0);
      for (int i = 1; i <= 5; i++) step(0, '0, 1, 32'hD0 + i);
      idle(6);

      // Reset with words queued
      step(0, '0, 1, 32'h11);
      step(0, '0, 1, 32'h12);
      pulse_reset();
      step(1, 32'hE0, 1, 32'hE1);
      idle(4);

      // Random phases with varying lane activity and rare resets
      for (int ph = 0; ph < 8; ph++) begin
         p0 = $urandom_range(100, 20);
         p1 = $urandom_range(100, 20);
         for (int c = 0; c < 80; c++) begin
            if ($urandom_range(199, 0) == 0) begin
               pulse_reset();
            end else begin
               step($urandom_range(99, 0) < p0, $urandom,
                    $urandom_range(99, 0) < p1, $urandom);
            end
         end
      end
      idle(12);

      cmp("drained", exp_q.size(), 0);
      @(negedge clk_2f);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
